ysyx_25030093_ifu: RTL and testbench
====================================

YSYX_25030093_IFU -- requirements
Module: ysyx_25030093_ifu

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait in R for rvalid before declaring a fault.
REQ-002 The block SHALL have parameter FAULT_INST, default 32'h00000013, meaning the instruction word presented when a fetch faults (NOP).
REQ-003 The block SHALL have port clock, input, 1, the single system clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port pc, input, 32, fetch address from the PC unit.
REQ-006 The block SHALL have port in_valid_pc, input, 1, one-cycle pulse marking pc as new.
REQ-007 The block SHALL have port araddr, output, 32, and port arvalid, output, 1, forming the read-address channel.
REQ-008 The block SHALL have port arready, input, 1, the read-address accept signal.
REQ-009 The block SHALL have ports rvalid, input, 1; rdata, input, 32; and rresp, input, 2, forming the read-data channel.
REQ-010 The block SHALL have port rready, output, 1, the read-data accept signal.
REQ-011 The block SHALL have ports inst, output, 32, and inst_pc, output, 32, carrying the fetched word and its address.
REQ-012 The block SHALL have port out_valid_IFU, output, 1, and port in_ready_IDU, input, 1, forming the decode handshake.
REQ-013 The block SHALL have port fetch_fault, output, 1, qualified by out_valid_IFU, and port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, AR, R and OUT.
REQ-015 In IDLE with in_valid_pc=1 and no drain pending, the block SHALL latch pc into inst_pc and araddr.
REQ-016 From REQ-015, the FSM SHALL go to AR if pc[1:0]==0; otherwise it SHALL go to OUT with fetch_fault=1 and inst=FAULT_INST, issuing no bus request.
REQ-017 The block SHALL drop in_valid_pc pulses arriving outside IDLE, or while a drain is pending, with no side effect.
REQ-018 arvalid SHALL be high exactly while in AR, and araddr SHALL remain stable until the arvalid&arready cycle, after which the FSM enters R.
REQ-019 rready SHALL equal (state==R) OR drain_pending.
REQ-020 When rvalid&rready occurs in R, the block SHALL capture rdata into inst, set fetch_fault=(rresp!=0), and enter OUT.
REQ-021 out_valid_IFU SHALL rise on the cycle after the rvalid&rready cycle, giving one cycle of latency.
REQ-022 A 9-bit wait counter SHALL clear on entry to R and increment each R cycle without rvalid.
REQ-023 When the wait counter reaches TIMEOUT, the block SHALL enter OUT with fetch_fault=1 and inst=FAULT_INST, and SHALL set drain_pending.
REQ-024 drain_pending SHALL clear on the next rvalid, and that response SHALL be discarded.
REQ-025 out_valid_IFU SHALL be high exactly in OUT, with inst, inst_pc and fetch_fault held stable until out_valid_IFU&in_ready_IDU.
REQ-026 On the out_valid_IFU&in_ready_IDU cycle, the FSM SHALL return to IDLE, and out_valid_IFU SHALL be low the next cycle.
REQ-027 The minimum fetch, with arready, rvalid and in_ready_IDU all immediate, SHALL take 4 cycles: IDLE, AR, R, OUT.
REQ-028 When arready and a simultaneous in_valid_pc both occur in AR, the block SHALL ignore the pulse, and the request in flight SHALL be unaffected.

Reset
REQ-029 On reset assertion, asynchronously and including mid-fetch, the block SHALL force state=IDLE, arvalid=0, out_valid_IFU=0, fetch_fault=0, drain_pending=0, wait counter=0, inst=0, inst_pc=0, araddr=0 and busy=0.
REQ-030 The block SHALL not track responses outstanding at reset; the bus slave is reset by the same reset.
REQ-031 The first in_valid_pc SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 Bench SHALL drive pc=0x20000000 with a pulse, arready=1, rvalid=1 the next cycle with rdata=0x00000297 and rresp=0, and in_ready_IDU=1, and SHALL check out_valid_IFU for exactly 1 cycle with inst=0x00000297, inst_pc=0x20000000 and fetch_fault=0.
REQ-033 Bench SHALL drive pc=0x20000002 and SHALL check that arvalid is never asserted and that OUT occurs with fetch_fault=1 and inst=0x00000013.
REQ-034 Bench SHALL hold rvalid low for 255 cycles and SHALL check fault output, drain_pending=1, and that no arvalid is issued for a new pc until a late rvalid is consumed with its rdata discarded.
REQ-035 Bench SHALL return rresp=2'b10 with rdata=0xDEADBEEF and SHALL check fetch_fault=1 and inst=0xDEADBEEF.
REQ-036 Bench SHALL hold in_ready_IDU low for 5 cycles in OUT while pulsing in_valid_pc, and SHALL check that outputs stay stable and the pulse is dropped.
REQ-037 Bench SHALL assert reset while in R and SHALL check that all outputs reach reset values before the next clock edge.

Source files
------------

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: issues one read per accepted PC and returns the word to decode.
// A read that never answers times out into a fault, and its late response is drained and dropped.
module ysyx_25030093_ifu #(
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        in_valid_pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        out_valid_IFU,
    input  logic        in_ready_IDU,
    output logic        fetch_fault,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_OUT
    } state_e;

    // The timeout fires on the edge that ends the TIMEOUT-th response-less R cycle.
    localparam logic [8:0] WAIT_LAST = 9'(TIMEOUT - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_araddr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_fault;
    logic        r_drain;
    logic [8:0]  r_wait_cnt;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_ar_fire;
    logic        w_r_fire;
    logic        w_timeout;
    logic        w_drain_done;

    assign w_misaligned = (pc[1:0] != 2'b00);
    assign w_accept     = (r_state == S_IDLE) && in_valid_pc && !r_drain;
    assign w_ar_fire    = (r_state == S_AR) && arready;
    assign w_r_fire     = (r_state == S_R) && rvalid;
    assign w_timeout    = (r_state == S_R) && !rvalid && (r_wait_cnt == WAIT_LAST);
    assign w_drain_done = r_drain && rvalid;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next-state default is assigned first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_misaligned ? S_OUT : S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    w_state_next = S_R;
                end
            end
            S_R: begin
                if (rvalid || w_timeout) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (in_ready_IDU) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: every datapath register is cleared by the asynchronous reset, since
    // inst, inst_pc and araddr must read zero immediately after reset asserts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_araddr   <= 32'h0;
            r_inst     <= 32'h0;
            r_inst_pc  <= 32'h0;
            r_fault    <= 1'b0;
            r_drain    <= 1'b0;
            r_wait_cnt <= 9'h0;
        end else begin
            if (w_accept) begin
                r_araddr  <= pc;
                r_inst_pc <= pc;
                r_fault   <= w_misaligned;
                if (w_misaligned) begin
                    r_inst <= FAULT_INST;
                end
            end

            if (w_r_fire) begin
                r_inst  <= rdata;
                r_fault <= (rresp != 2'b00);
            end else if (w_timeout) begin
                r_inst  <= FAULT_INST;
                r_fault <= 1'b1;
            end

            if (w_ar_fire) begin
                r_wait_cnt <= 9'h0;
            end else if ((r_state == S_R) && !rvalid) begin
                r_wait_cnt <= r_wait_cnt + 9'd1;
            end

            // The abandoned read still owes one response; swallow it before the next fetch.
            if (w_timeout) begin
                r_drain <= 1'b1;
            end else if (w_drain_done) begin
                r_drain <= 1'b0;
            end
        end
    end

    assign araddr        = r_araddr;
    assign arvalid       = (r_state == S_AR);
    assign rready        = (r_state == S_R) || r_drain;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign out_valid_IFU = (r_state == S_OUT);
    assign fetch_fault   = r_fault;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Directed bench for the fetch unit: normal fetch, misaligned PC, bus error,
// decode backpressure, response timeout with drain, and reset during a read.
module tb_ysyx_25030093_ifu;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        in_valid_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        out_valid_IFU;
    logic        in_ready_IDU;
    logic        fetch_fault;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ar_cnt  = 0;

    ysyx_25030093_ifu #(
        .TIMEOUT    (255),
        .FAULT_INST (32'h0000_0013)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .in_valid_pc   (in_valid_pc),
        .araddr        (araddr),
        .arvalid       (arvalid),
        .arready       (arready),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .rresp         (rresp),
        .rready        (rready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .out_valid_IFU (out_valid_IFU),
        .in_ready_IDU  (in_ready_IDU),
        .fetch_fault   (fetch_fault),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Number of edges on which a read address was presented.
    always @(posedge clock) begin
        if (arvalid) ar_cnt <= ar_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // From an IDLE negedge: pulse pc, answer immediately, stop at the OUT negedge.
    task automatic fetch_basic(input [31:0] addr, input [31:0] data, input [1:0] resp);
        pc          = addr;
        in_valid_pc = 1'b1;
        @(negedge clock);
        in_valid_pc = 1'b0;
        check("ar_valid", {31'h0, arvalid}, 32'h1);
        check("ar_addr", araddr, addr);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        @(negedge clock);
        check("r_ready", {31'h0, rready}, 32'h1);
        check("r_no_out", {31'h0, out_valid_IFU}, 32'h0);
        @(negedge clock);
        rvalid = 1'b0;
        check("out_valid", {31'h0, out_valid_IFU}, 32'h1);
    endtask

    initial begin
        int c0;
        int r_cycles;

        reset        = 1'b1;
        pc           = 32'h0;
        in_valid_pc  = 1'b0;
        arready      = 1'b1;
        rvalid       = 1'b0;
        rdata        = 32'h0;
        rresp        = 2'b00;
        in_ready_IDU = 1'b1;

        @(negedge clock);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_arvalid", {31'h0, arvalid}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid_IFU}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_araddr", araddr, 32'h0);
        reset = 1'b0;

        // Normal fetch: out_valid for exactly one cycle.
        @(negedge clock);
        fetch_basic(32'h2000_0000, 32'h0000_0297, 2'b00);
        check("t1_inst", inst, 32'h0000_0297);
        check("t1_inst_pc", inst_pc, 32'h2000_0000);
        check("t1_fault", {31'h0, fetch_fault}, 32'h0);
        @(negedge clock);
        check("t1_out_one_cycle", {31'h0, out_valid_IFU}, 32'h0);
        check("t1_idle", {31'h0, busy}, 32'h0);

        // Misaligned PC: straight to OUT with a fault, no read issued.
        c0          = ar_cnt;
        pc          = 32'h2000_0002;
        in_valid_pc = 1'b1;
        @(negedge clock);
        in_valid_pc = 1'b0;
        check("t2_out_valid", {31'h0, out_valid_IFU}, 32'h1);
        check("t2_fault", {31'h0, fetch_fault}, 32'h1);
        check("t2_inst", inst, 32'h0000_0013);
        check("t2_inst_pc", inst_pc, 32'h2000_0002);
        @(negedge clock);
        check("t2_idle", {31'h0, busy}, 32'h0);
        check("t2_no_arvalid", ar_cnt - c0, 32'h0);

        // Bus error response: data kept, fault flagged.
        fetch_basic(32'h2000_0100, 32'hDEAD_BEEF, 2'b10);
        check("t3_fault", {31'h0, fetch_fault}, 32'h1);
        check("t3_inst", inst, 32'hDEAD_BEEF);
        @(negedge clock);

        // Decode backpressure: outputs hold, pc pulses ignored.
        in_ready_IDU = 1'b0;
        fetch_basic(32'h2000_0200, 32'h1234_5678, 2'b00);
        pc = 32'h3000_0000;
        for (int i = 0; i < 5; i++) begin
            in_valid_pc = 1'b1;
            @(negedge clock);
            check("t4_hold_valid", {31'h0, out_valid_IFU}, 32'h1);
            check("t4_hold_inst", inst, 32'h1234_5678);
            check("t4_hold_pc", inst_pc, 32'h2000_0200);
            check("t4_hold_fault", {31'h0, fetch_fault}, 32'h0);
        end
        in_valid_pc  = 1'b0;
        in_ready_IDU = 1'b1;
        @(negedge clock);
        check("t4_released", {31'h0, busy}, 32'h0);
        check("t4_pulse_dropped", araddr, 32'h2000_0200);

        // Timeout: 255 silent R cycles, then fault and drain of the late response.
        pc          = 32'h2000_0300;
        in_valid_pc = 1'b1;
        @(negedge clock);
        in_valid_pc = 1'b0;
        check("t5_ar", {31'h0, arvalid}, 32'h1);
        r_cycles = 0;
        while (!out_valid_IFU && r_cycles < 400) begin
            @(negedge clock);
            if (!out_valid_IFU) r_cycles++;
        end
        check("t5_out_reached", {31'h0, out_valid_IFU}, 32'h1);
        check("t5_r_cycles", r_cycles, 32'd255);
        check("t5_fault", {31'h0, fetch_fault}, 32'h1);
        check("t5_inst", inst, 32'h0000_0013);
        check("t5_inst_pc", inst_pc, 32'h2000_0300);
        check("t5_drain_pending", {31'h0, rready}, 32'h1);
        @(negedge clock);
        check("t5_idle", {31'h0, busy}, 32'h0);
        check("t5_still_draining", {31'h0, rready}, 32'h1);
        c0          = ar_cnt;
        pc          = 32'h2000_0400;
        in_valid_pc = 1'b1;
        @(negedge clock);
        in_valid_pc = 1'b0;
        check("t5_blocked_busy", {31'h0, busy}, 32'h0);
        check("t5_blocked_addr", araddr, 32'h2000_0300);
        rvalid = 1'b1;
        rdata  = 32'hBAAD_F00D;
        @(negedge clock);
        rvalid = 1'b0;
        check("t5_drained", {31'h0, rready}, 32'h0);
        check("t5_discarded", {31'h0, out_valid_IFU}, 32'h0);
        check("t5_no_ar", ar_cnt - c0, 32'h0);
        fetch_basic(32'h2000_0400, 32'h0010_0073, 2'b00);
        check("t5_next_inst", inst, 32'h0010_0073);
        check("t5_next_fault", {31'h0, fetch_fault}, 32'h0);
        @(negedge clock);

        // Reset asserted while waiting in R; outputs clear before the next edge.
        pc          = 32'h2000_0500;
        in_valid_pc = 1'b1;
        @(negedge clock);
        in_valid_pc = 1'b0;
        @(negedge clock);
        check("t6_in_r", {31'h0, rready}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_arvalid", {31'h0, arvalid}, 32'h0);
        check("t6_rready", {31'h0, rready}, 32'h0);
        check("t6_out_valid", {31'h0, out_valid_IFU}, 32'h0);
        check("t6_fault", {31'h0, fetch_fault}, 32'h0);
        check("t6_inst", inst, 32'h0);
        check("t6_inst_pc", inst_pc, 32'h0);
        check("t6_araddr", araddr, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        fetch_basic(32'h2000_0600, 32'h0000_0513, 2'b00);
        check("t6_after_inst", inst, 32'h0000_0513);
        check("t6_after_pc", inst_pc, 32'h2000_0600);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
